// File: rtl/reset_sequencer_if.sv
// Purpose: groups the sequencer's request/ack/status signals into one bundle between
//   the reset sequencer (master) and the reset domains and requester it serves (slave).
// Ports: soft_rst_req_i, stage_ack_i (into sequencer); stage_rst_no, busy_o, done_o,
//   timeout_o, fail_stage_o (out of sequencer).
interface reset_sequencer_if #(
  parameter int NumStages = 3
);
  localparam int FailW = (NumStages > 1) ? $clog2(NumStages) : 1;

  logic                 soft_rst_req_i;
  logic [NumStages-1:0] stage_ack_i;
  logic [NumStages-1:0] stage_rst_no;
  logic                 busy_o;
  logic                 done_o;
  logic                 timeout_o;
  logic [FailW-1:0]     fail_stage_o;

  modport master (
    input  soft_rst_req_i, stage_ack_i,
    output stage_rst_no, busy_o, done_o, timeout_o, fail_stage_o
  );

  modport slave (
    output soft_rst_req_i, stage_ack_i,
    input  stage_rst_no, busy_o, done_o, timeout_o, fail_stage_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Purpose: releases NumStages reset domains one at a time, each after the previous acks.
// Latency: 2-flop sync + HoldCycles, then 2 cycles from each ack to the next stage release.
// Backpressure: none; a stage that never acks stalls the sequence (watchdog -> ERROR).
// Ports: clk_i, rst_ni (async active-low), bus (reset_sequencer_if.master).
// Build option: define RESET_SEQUENCER_WATCHDOG_EN to enable the ack timeout watchdog;
//   without it WAIT_ACK waits forever and timeout_o/fail_stage_o are tied low.
// The NumStages parameter must match the one the bus interface was built with.
module reset_sequencer #(
  parameter int NumStages  = 3,
  parameter int HoldCycles = 2,
  parameter int AckTimeout = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  reset_sequencer_if.master   bus
);

  localparam int KW     = (NumStages > 1) ? $clog2(NumStages) : 1;
  localparam int CntMax = (HoldCycles > AckTimeout) ? HoldCycles : AckTimeout;
  localparam int CW     = $clog2(CntMax + 1);

  localparam logic [KW-1:0] LastK    = KW'(NumStages - 1);
  localparam logic [CW-1:0] HoldLast = CW'(HoldCycles - 1);
`ifdef RESET_SEQUENCER_WATCHDOG_EN
  localparam logic [CW-1:0] AckLast  = CW'(AckTimeout - 1);
`endif

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_HOLD,
    ST_RELEASE,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_sat;
  logic [NumStages-1:0] rst_n_q, rst_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sync_q1, sync_q2;
  logic                 soft_take;

  // Deassertion of rst_ni is asynchronous; the FSM only moves once the
  // release has propagated through both flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= 1'b1;
      sync_q2 <= sync_q1;
    end
  end

  // Counter holds at all-ones instead of wrapping.
  assign cnt_sat   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  // Soft reset is ignored while still synchronising the power-on release.
  assign soft_take = (state_q != ST_SYNC) && bus.soft_rst_req_i;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;

    if (soft_take) begin
      // Wins over any ack or timeout seen in the same cycle.
      state_d = ST_HOLD;
      cnt_d   = '0;
      k_d     = '0;
      rst_n_d = '0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (sync_q2) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          rst_n_d = '0;
          if (cnt_q >= HoldLast) begin
            state_d = ST_RELEASE;
            k_d     = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
        ST_RELEASE: begin
          rst_n_d[k_q] = 1'b1;
          state_d      = ST_WAIT_ACK;
          cnt_d        = '0;
        end
        ST_WAIT_ACK: begin
          // Only the ack of the stage just released matters.
          if (bus.stage_ack_i[k_q]) begin
            if (k_q == LastK) begin
              state_d = ST_DONE;
            end else begin
              k_d     = k_q + 1'b1;
              state_d = ST_RELEASE;
            end
          end
`ifdef RESET_SEQUENCER_WATCHDOG_EN
          else if (cnt_q >= AckLast) begin
            state_d = ST_ERROR;
            rst_n_d = '0;
          end
`endif
          else begin
            cnt_d = cnt_sat;
          end
        end
        ST_DONE: begin
          // Sticky until a soft or hard reset; late ack drops are ignored.
        end
        ST_ERROR: begin
          rst_n_d = '0;
        end
        default: begin
          state_d = ST_SYNC;
          rst_n_d = '0;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with state_q.
  assign busy_d = (state_d == ST_SYNC) || (state_d == ST_HOLD) ||
                  (state_d == ST_RELEASE) || (state_d == ST_WAIT_ACK);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_SYNC;
      k_q     <= '0;
      cnt_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RESET_SEQUENCER_WATCHDOG_EN
  logic          timeout_q;
  logic [KW-1:0] fail_q;
  logic          timeout_set;

  assign timeout_set = (state_q == ST_WAIT_ACK) && (state_d == ST_ERROR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
      fail_q    <= '0;
    end else if (timeout_set) begin
      timeout_q <= 1'b1;
      fail_q    <= k_q;
    end else if (soft_take) begin
      timeout_q <= 1'b0;
    end
  end

  assign bus.timeout_o    = timeout_q;
  assign bus.fail_stage_o = fail_q;
`else
  assign bus.timeout_o    = 1'b0;
  assign bus.fail_stage_o = '0;
`endif

  assign bus.stage_rst_no = rst_n_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NumStages, default 3, number of sequenced reset domains (1..8).
REQ-002 Parameter HoldCycles, default 2, cycles all stages stay in reset after synchronized release (>=1).
REQ-003 Parameter AckTimeout, default 64, max cycles waiting for one stage ack (>=2).
REQ-004 clk_i  in  1  single clock for all logic.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 soft_rst_req_i  in  1  level request to re-run the full sequence.
REQ-007 stage_ack_i  in  NumStages  stage k reports "out of reset and ready".
REQ-008 stage_rst_no  out  NumStages  active-low reset to stage k.
REQ-009 busy_o  out  1  sequence in progress.
REQ-010 done_o  out  1  all stages released and acknowledged.
REQ-011 timeout_o  out  1  sticky ack-timeout error.
REQ-012 fail_stage_o  out  max(1,$clog2(NumStages))  index of the stage that timed out.

Function
REQ-013 FSM states SHALL be SYNC, HOLD, RELEASE, WAIT_ACK, DONE, ERROR; stage index k and a cycle counter SHALL be held in registers.
REQ-014 SYNC: a 2-flop synchronizer SHALL clear asynchronously with rst_ni and fill with 1s; FSM SHALL leave SYNC on the cycle the second flop reads 1.
REQ-015 HOLD: all stage_rst_no = 0, counter counts HoldCycles, then RELEASE with k = 0.
REQ-016 RELEASE (1 cycle): stage_rst_no[k] SHALL go 1 at the end of this cycle and stay 1; FSM -> WAIT_ACK, counter cleared.
REQ-017 WAIT_ACK: stage_ack_i[k] sampled 1 -> if k == NumStages-1 go DONE, else k <= k+1 and go RELEASE; acks for stages other than k SHALL be ignored.
REQ-018 Stage k+1 SHALL be released exactly 2 cycles after the cycle stage_ack_i[k] is sampled high.
REQ-019 Acks dropping after acceptance SHALL be ignored; DONE is left only by reset or soft reset.
REQ-020 busy_o = 1 in SYNC, HOLD, RELEASE, WAIT_ACK; done_o = 1 only in DONE; both registered from state.
REQ-021 soft_rst_req_i high in any state except SYNC SHALL, next cycle, drive all stage_rst_no = 0, clear timeout_o, and enter HOLD with counter cleared; request held high keeps FSM in HOLD.
REQ-022 Soft reset takes priority over a simultaneous ack or timeout.
REQ-023 Counter SHALL saturate, never wrap.

Reset
REQ-024 rst_ni low SHALL immediately (asynchronously) force state SYNC, stage_rst_no = 0, busy_o = 1, done_o = 0, timeout_o = 0, fail_stage_o = 0, k = 0, counter = 0.
REQ-025 rst_ni asserted mid-sequence SHALL abort it; after release the full sequence restarts from stage 0.

Configuration
REQ-026 With RESET_SEQUENCER_WATCHDOG_EN defined: in WAIT_ACK, counter reaching AckTimeout without ack SHALL enter ERROR, set timeout_o = 1, latch fail_stage_o = k, and drive all stage_rst_no = 0; an ack sampled on the timeout cycle SHALL win.
REQ-027 ERROR: busy_o = 0, done_o = 0; left only via soft reset or rst_ni.
REQ-028 Without RESET_SEQUENCER_WATCHDOG_EN: WAIT_ACK waits indefinitely, ERROR unreachable, timeout_o and fail_stage_o tied 0.

Verification (NumStages=3, HoldCycles=2, AckTimeout=8)
REQ-029 Release rst_ni, ack each stage 1 cycle after its release -> stage_rst_no 000->001->011->111 with 2-cycle spacing after each ack, done_o=1, busy_o=0.
REQ-030 Watchdog on, stage 1 never acks -> 8 cycles after release of stage 1: timeout_o=1, fail_stage_o=1, stage_rst_no=000.
REQ-031 From ERROR pulse soft_rst_req_i 1 cycle, all acks prompt -> timeout_o clears, full sequence repeats, done_o=1.
REQ-032 Assert rst_ni low while waiting for stage 2 ack -> stage_rst_no=000 same cycle; after release sequence restarts at stage 0.
REQ-033 Stage 2 ack and soft_rst_req_i high same cycle -> HOLD entered, done_o stays 0, stage_rst_no=000.
REQ-034 Watchdog off, stage 0 acks after 200 cycles -> no timeout, sequence completes, timeout_o=0 throughout.
